// File: rtl/coke_vend_ctrl.sv
// Transaction controller for the Coke vending machine: accumulates coins, decides
// sale/refund, pulses dispense, and drives credit/change plus the display mux select.
module coke_vend_ctrl #(
    parameter int unsigned PRICE = 7,
    parameter int unsigned HOLD  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       coin1,
    input  logic       coin5,
    input  logic       buy,
    input  logic       cancel,
    output logic [3:0] credit,
    output logic [3:0] change,
    output logic       show_change,
    output logic       dispense,
    output logic       coin_reject,
    output logic       short
);

    localparam int unsigned CW = 4;
    localparam int unsigned SW = 5;
    localparam int unsigned HW = 8;

    localparam logic [SW-1:0] MAX_CREDIT = SW'(15);
    localparam logic [SW-1:0] PRICE_W    = SW'(PRICE);
    localparam logic [CW-1:0] PRICE_C    = CW'(PRICE);
    localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    state_t          r_state;
    logic [HW-1:0]   r_hold;
    logic [CW-1:0]   r_credit;
    logic [CW-1:0]   r_change;
    logic            r_show;
    logic            r_dispense;
    logic            r_reject;
    logic            r_short;

    state_t          w_state_nxt;
    logic [HW-1:0]   w_hold_nxt;
    logic [CW-1:0]   w_credit_nxt;
    logic [CW-1:0]   w_change_nxt;
    logic            w_show_nxt;
    logic            w_dispense_nxt;
    logic            w_reject_nxt;
    logic            w_short_nxt;

    logic            w_coin_any;
    logic [SW-1:0]   w_sum;
    logic [SW-1:0]   w_total;
    logic            w_can_pay;

    // Coin arithmetic is done in 5 bits so an overflow past 15 is visible.
    assign w_coin_any = coin1 | coin5;
    assign w_sum      = (coin1 ? SW'(1) : SW'(0)) + (coin5 ? SW'(5) : SW'(0));
    assign w_total    = {1'b0, r_credit} + w_sum;
    assign w_can_pay  = ({1'b0, r_credit} >= PRICE_W);

    // State and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_hold     <= '0;
            r_credit   <= '0;
            r_change   <= '0;
            r_show     <= 1'b0;
            r_dispense <= 1'b0;
            r_reject   <= 1'b0;
            r_short    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold     <= w_hold_nxt;
            r_credit   <= w_credit_nxt;
            r_change   <= w_change_nxt;
            r_show     <= w_show_nxt;
            r_dispense <= w_dispense_nxt;
            r_reject   <= w_reject_nxt;
            r_short    <= w_short_nxt;
        end
    end

    // Next state and next output values; priority cancel > buy > coins.
    always_comb begin
        w_state_nxt    = r_state;
        w_hold_nxt     = r_hold;
        w_credit_nxt   = r_credit;
        w_change_nxt   = r_change;
        w_show_nxt     = r_show;
        w_dispense_nxt = 1'b0;
        w_reject_nxt   = 1'b0;
        w_short_nxt    = 1'b0;

        case (r_state)
            ST_IDLE, ST_ACCUM: begin
                if (cancel) begin
                    w_reject_nxt = w_coin_any;
                    if (r_state == ST_ACCUM) begin
                        w_change_nxt = r_credit;
                        w_credit_nxt = '0;
                        w_show_nxt   = 1'b1;
                        w_hold_nxt   = HOLD_LOAD;
                        w_state_nxt  = ST_SHOW;
                    end
                end else if (buy) begin
                    w_reject_nxt = w_coin_any;
                    if (w_can_pay) begin
                        w_dispense_nxt = 1'b1;
                        w_change_nxt   = r_credit - PRICE_C;
                        w_credit_nxt   = '0;
                        w_show_nxt     = 1'b1;
                        w_hold_nxt     = HOLD_LOAD;
                        w_state_nxt    = ST_SHOW;
                    end else begin
                        w_short_nxt = 1'b1;
                    end
                end else if (w_coin_any) begin
                    if (w_total <= MAX_CREDIT) begin
                        w_credit_nxt = w_total[CW-1:0];
                        w_state_nxt  = ST_ACCUM;
                    end else begin
                        w_reject_nxt = 1'b1;
                    end
                end
            end
            ST_SHOW: begin
                w_reject_nxt = w_coin_any;
                if (r_hold == '0) begin
                    w_change_nxt = '0;
                    w_show_nxt   = 1'b0;
                    w_state_nxt  = ST_IDLE;
                end else begin
                    w_hold_nxt = r_hold - HW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign credit      = r_credit;
    assign change      = r_change;
    assign show_change = r_show;
    assign dispense    = r_dispense;
    assign coin_reject = r_reject;
    assign short       = r_short;

endmodule
